// File: rtl/shift_sub_divider.sv
// Sequential restoring divider: 2W-bit dividend / W-bit divisor -> W-bit quotient and remainder.
// Optional DIV_OVF_CHECK_EN: flag quotient overflow (incl. D==0) on capture and finish in one cycle.

package q_8_39_pkg;
  localparam int unsigned data_width = 4;
endpackage

module shift_sub_divider #(
  parameter int unsigned DATA_WIDTH = q_8_39_pkg::data_width
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      start,
  input  logic [2*DATA_WIDTH-1:0]   N,
  input  logic [DATA_WIDTH-1:0]     D,
  output logic                      rdy,
  output logic [DATA_WIDTH-1:0]     Q,
  output logic [DATA_WIDTH-1:0]     R,
  output logic                      ovf
);

  localparam int unsigned W  = DATA_WIDTH;
  localparam int unsigned CW = $clog2(W + 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1
  } state_e;

  state_e          state_q, state_d;
  logic [W:0]      rem_q, rem_d;
  logic [W-1:0]    quo_q, quo_d;
  logic [W-1:0]    dsr_q, dsr_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            rdy_q, rdy_d;
  logic [W-1:0]    quot_out_q, quot_out_d;
  logic [W-1:0]    rmd_out_q, rmd_out_d;
  logic            ovf_q, ovf_d;

  logic [W+1:0]    rem_sh;
  logic [W+1:0]    trial;
  logic [W-1:0]    quo_sh;

  // One restoring step: shift {rem,quo} left, trial-subtract the divisor.
  assign rem_sh = {rem_q, quo_q[W-1]};
  assign trial  = rem_sh - {2'b00, dsr_q};
  assign quo_sh = {quo_q[W-2:0], ~trial[W+1]};

  always_comb begin
    state_d    = state_q;
    rem_d      = rem_q;
    quo_d      = quo_q;
    dsr_d      = dsr_q;
    cnt_d      = cnt_q;
    rdy_d      = rdy_q;
    quot_out_d = quot_out_q;
    rmd_out_d  = rmd_out_q;
    ovf_d      = ovf_q;

    case (state_q)
      S_IDLE: begin
`ifdef DIV_OVF_CHECK_EN
        // rdy low while idle marks the single-cycle overflow completion.
        if (!rdy_q) begin
          quot_out_d = '1;
          rmd_out_d  = '0;
          ovf_d      = 1'b1;
          rdy_d      = 1'b1;
        end else
`endif
        if (start) begin
          rem_d = {1'b0, N[2*W-1:W]};
          quo_d = N[W-1:0];
          dsr_d = D;
          cnt_d = CW'(W);
          rdy_d = 1'b0;
`ifdef DIV_OVF_CHECK_EN
          state_d = (N[2*W-1:W] >= D) ? S_IDLE : S_RUN;
`else
          state_d = S_RUN;
`endif
        end
      end

      S_RUN: begin
        rem_d = trial[W+1] ? rem_sh[W:0] : trial[W:0];
        quo_d = quo_sh;
        cnt_d = cnt_q - CW'(1);
        if (cnt_q == CW'(1)) begin
          quot_out_d = quo_sh;
          rmd_out_d  = trial[W+1] ? rem_sh[W-1:0] : trial[W-1:0];
          ovf_d      = 1'b0;
          rdy_d      = 1'b1;
          state_d    = S_IDLE;
        end
      end

      default: begin
        state_d = S_IDLE;
        rdy_d   = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= S_IDLE;
      rem_q      <= '0;
      quo_q      <= '0;
      dsr_q      <= '0;
      cnt_q      <= '0;
      rdy_q      <= 1'b1;
      quot_out_q <= '0;
      rmd_out_q  <= '0;
      ovf_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      rem_q      <= rem_d;
      quo_q      <= quo_d;
      dsr_q      <= dsr_d;
      cnt_q      <= cnt_d;
      rdy_q      <= rdy_d;
      quot_out_q <= quot_out_d;
      rmd_out_q  <= rmd_out_d;
      ovf_q      <= ovf_d;
    end
  end

  assign rdy = rdy_q;
  assign Q   = quot_out_q;
  assign R   = rmd_out_q;
  assign ovf = ovf_q;

endmodule

// File: tb/tb_shift_sub_divider.sv
// Bench for shift_sub_divider: latency/result model checked every cycle plus directed literal checks.
module tb_shift_sub_divider;

  localparam int unsigned W = 4;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic [7:0] N;
  logic [3:0] D;
  logic       rdy;
  logic [3:0] Q;
  logic [3:0] R;
  logic       ovf;

  int total = 0;
  int bad   = 0;

  shift_sub_divider dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .N     (N),
    .D     (D),
    .rdy   (rdy),
    .Q     (Q),
    .R     (R),
    .ovf   (ovf)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Model: an operation is a countdown of its latency, then the arithmetic result appears.
  int       m_left = 0;
  logic     m_rdy  = 1'b1;
  logic     m_ovf  = 1'b0;
  logic     m_chk  = 1'b1;
  int       m_q    = 0;
  int       m_r    = 0;
  int       p_q, p_r, nn, dd;
  logic     p_ovf, p_chk, of;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_left = 0; m_rdy = 1'b1; m_ovf = 1'b0; m_chk = 1'b1; m_q = 0; m_r = 0;
    end else if (m_left == 0) begin
      if (start) begin
        nn = int'(N);
        dd = int'(D);
        of = (nn / 16) >= dd;
        p_ovf = 1'b0;
        p_chk = 1'b1;
        m_left = W;
        if (!of) begin
          p_q = nn / dd;
          p_r = nn % dd;
        end else begin
`ifdef DIV_OVF_CHECK_EN
          p_q = 15; p_r = 0; p_ovf = 1'b1; m_left = 1;
`else
          p_q = 0; p_r = 0; p_chk = 1'b0;
`endif
        end
        m_rdy = 1'b0;
      end
    end else begin
      m_left--;
      if (m_left == 0) begin
        m_rdy = 1'b1; m_q = p_q; m_r = p_r; m_ovf = p_ovf; m_chk = p_chk;
      end
    end
  end

  always @(negedge clk) begin
    if (!rst) begin
      check("cyc_rdy", int'(rdy), int'(m_rdy));
      if (m_rdy) begin
        check("cyc_ovf", int'(ovf), int'(m_ovf));
        if (m_chk) begin
          check("cyc_Q", int'(Q), m_q);
          check("cyc_R", int'(R), m_r);
        end
      end
    end
  end

  task automatic do_op(input logic [7:0] n, input logic [3:0] d, output int low);
    @(negedge clk);
    start = 1'b1; N = n; D = d;
    @(negedge clk);
    start = 1'b0;
    low = 0;
    while (!rdy && low < 40) begin
      low++;
      @(negedge clk);
    end
    if (!rdy) check("rdy_timeout", 0, 1);
  endtask

  int low;
  int sn[4] = '{100, 77, 30, 143};
  int sd[4] = '{9, 8, 2, 12};
  int sq[4] = '{11, 9, 15, 11};
  int sr[4] = '{1, 5, 0, 11};

  initial begin
    #5ms;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b0; start = 1'b0; N = '0; D = '0;
    #2 rst = 1'b1;
    repeat (2) @(negedge clk);
    check("rst_rdy", int'(rdy), 1);
    check("rst_Q", int'(Q), 0);
    check("rst_R", int'(R), 0);
    check("rst_ovf", int'(ovf), 0);
    rst = 1'b0;

    do_op(8'd45, 4'd7, low);
    check("t45_low", low, 4);
    check("t45_Q", int'(Q), 6);
    check("t45_R", int'(R), 3);
    check("t45_ovf", int'(ovf), 0);

    for (int d = 1; d <= 15; d++) begin
      for (int n = 0; n < d * 16; n++) begin
        do_op(8'(n), 4'(d), low);
        check("sweep_Q", int'(Q), n / d);
        check("sweep_R", int'(R), n % d);
      end
    end

`ifdef DIV_OVF_CHECK_EN
    do_op(8'h50, 4'h5, low);
    check("ovf50_low", low, 1);
    check("ovf50_Q", int'(Q), 15);
    check("ovf50_R", int'(R), 0);
    check("ovf50_ovf", int'(ovf), 1);
    do_op(8'h4F, 4'h5, low);
    check("ok4f_low", low, 4);
    check("ok4f_Q", int'(Q), 15);
    check("ok4f_R", int'(R), 4);
    check("ok4f_ovf", int'(ovf), 0);
    do_op(8'h12, 4'h0, low);
    check("d0_low", low, 1);
    check("d0_ovf", int'(ovf), 1);
`else
    do_op(8'h50, 4'h5, low);
    check("nochk_low", low, 4);
    check("nochk_ovf", int'(ovf), 0);
`endif

    // start held high; operands change two cycles after each capture.
    @(negedge clk);
    start = 1'b1; N = 8'(sn[0]); D = 4'(sd[0]);
    for (int i = 0; i < 4; i++) begin
      for (int j = 0; j < 5; j++) begin
        @(negedge clk);
        check("stream_rdy", int'(rdy), int'(j == 4));
        if (j == 1 && i < 3) begin
          N = 8'(sn[i+1]); D = 4'(sd[i+1]);
        end
        if (j == 4) begin
          check("stream_Q", int'(Q), sq[i]);
          check("stream_R", int'(R), sr[i]);
          if (i == 3) start = 1'b0;
        end
      end
    end

    // Asynchronous reset two cycles into an operation.
    @(negedge clk);
    start = 1'b1; N = 8'd200; D = 4'd13;
    @(negedge clk);
    start = 1'b0;
    repeat (2) @(negedge clk);
    check("pre_rst_rdy", int'(rdy), 0);
    #1 rst = 1'b1;
    #1;
    check("arst_rdy", int'(rdy), 1);
    check("arst_Q", int'(Q), 0);
    check("arst_R", int'(R), 0);
    @(negedge clk);
    rst = 1'b0;
    do_op(8'd200, 4'd13, low);
    check("t200_low", low, 4);
    check("t200_Q", int'(Q), 15);
    check("t200_R", int'(R), 5);

    repeat (3) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
